escritor_quadro: RTL and testbench



---
 rtl/escritor_quadro_if.sv | 26 ++
 rtl/escritor_quadro.sv | 178 +++++++++++++++++
 tb/tb_escritor_quadro.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/escritor_quadro_if.sv
// Custom-instruction command bus between the processor and the frame writer.
// The processor drives a command word, a payload and a one-cycle start strobe.
// The writer answers with a one-cycle done pulse and a result word.
interface escritor_quadro_if;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        start;
  logic [31:0] result;
  logic        done;

  modport master (
    output dataa,
    output datab,
    output start,
    input  result,
    input  done
  );

  modport slave (
    input  dataa,
    input  datab,
    input  start,
    output result,
    output done
  );
endinterface

// File: rtl/escritor_quadro.sv
// Writer side of the 64x64 1-bit frame RAM used by the VGA scan-out.
// Turns custom-instruction commands into RAM write cycles:
//   opcode 0 PIXEL : one write of datab[0] at the given address
//   opcode 1 WORD  : WORD_BITS writes of datab[i] at addr+i (wrapping)
//   opcode 2 FILL  : datab[0] written to every address, 0 upwards
//   opcode 3 ID    : no writes, returns ID_VALUE
//   others         : no writes, returns all ones
// Write opcodes return the number of writes issued.
module escritor_quadro #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          WORD_BITS  = 32,
  parameter logic [31:0] ID_VALUE   = 32'h5646_0040
) (
  input  logic                  clk,
  input  logic                  reset,
  escritor_quadro_if.slave      cmd,
  output logic                  wren,
  output logic                  data,
  output logic [ADDR_WIDTH-1:0] wraddress
);

  localparam int TOTAL_W = ADDR_WIDTH + 1;
  localparam int IDX_W   = $clog2(WORD_BITS);

  localparam logic [3:0] OP_PIXEL = 4'd0;
  localparam logic [3:0] OP_WORD  = 4'd1;
  localparam logic [3:0] OP_FILL  = 4'd2;
  localparam logic [3:0] OP_ID    = 4'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0]  cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]       idx_r, idx_nxt_s;
  logic [WORD_BITS-1:0]   payload_r, payload_nxt_s;
  logic [TOTAL_W-1:0]     total_r, total_nxt_s;
  logic                   wren_r, wren_nxt_s;
  logic                   data_r, data_nxt_s;
  logic [ADDR_WIDTH-1:0]  wraddress_r, wraddress_nxt_s;
  logic                   done_r, done_nxt_s;
  logic [31:0]            result_r, result_nxt_s;

  logic [3:0]             opcode_s;
  logic [ADDR_WIDTH-1:0]  cmd_addr_s;
  logic [TOTAL_W-1:0]     n_writes_s;
  logic                   unused_dataa_s;

  assign opcode_s       = cmd.dataa[31:28];
  assign cmd_addr_s     = cmd.dataa[ADDR_WIDTH-1:0];
  // Bits between the opcode and the address carry no meaning.
  assign unused_dataa_s = ^cmd.dataa[27:ADDR_WIDTH];

  // Number of RAM writes the incoming opcode will issue (zero for non-write opcodes).
  always_comb begin
    n_writes_s = '0;
    case (opcode_s)
      OP_PIXEL: n_writes_s = TOTAL_W'(1);
      OP_WORD:  n_writes_s = TOTAL_W'(WORD_BITS);
      OP_FILL:  n_writes_s = TOTAL_W'(1) << ADDR_WIDTH;
      default:  n_writes_s = '0;
    endcase
  end

  // Next-state and next-output logic; every register holds unless a state says otherwise.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    idx_nxt_s       = idx_r;
    payload_nxt_s   = payload_r;
    total_nxt_s     = total_r;
    wren_nxt_s      = 1'b0;
    data_nxt_s      = data_r;
    wraddress_nxt_s = wraddress_r;
    done_nxt_s      = 1'b0;
    result_nxt_s    = result_r;

    case (state_r)
      IDLE: begin
        if (cmd.start) begin
          case (opcode_s)
            OP_PIXEL, OP_WORD, OP_FILL: begin
              // First write is presented right away; counter tracks the remaining ones.
              state_nxt_s     = WRITE;
              total_nxt_s     = n_writes_s;
              cnt_nxt_s       = ADDR_WIDTH'(n_writes_s - TOTAL_W'(1));
              idx_nxt_s       = IDX_W'(1);
              payload_nxt_s   = (opcode_s == OP_FILL) ? {WORD_BITS{cmd.datab[0]}}
                                                      : cmd.datab[WORD_BITS-1:0];
              wraddress_nxt_s = (opcode_s == OP_FILL) ? '0 : cmd_addr_s;
              data_nxt_s      = cmd.datab[0];
              wren_nxt_s      = 1'b1;
            end
            OP_ID: begin
              state_nxt_s  = FINISH;
              done_nxt_s   = 1'b1;
              result_nxt_s = ID_VALUE;
            end
            default: begin
              state_nxt_s  = FINISH;
              done_nxt_s   = 1'b1;
              result_nxt_s = 32'hFFFF_FFFF;
            end
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end

      WRITE: begin
        if (cnt_r == '0) begin
          // Last write was on the RAM port this cycle; report the write count.
          state_nxt_s  = FINISH;
          done_nxt_s   = 1'b1;
          result_nxt_s = 32'(total_r);
        end else begin
          cnt_nxt_s       = cnt_r - ADDR_WIDTH'(1);
          wren_nxt_s      = 1'b1;
          wraddress_nxt_s = wraddress_r + ADDR_WIDTH'(1);
          data_nxt_s      = payload_r[idx_r];
          idx_nxt_s       = idx_r + IDX_W'(1);
        end
      end

      FINISH: begin
        state_nxt_s = IDLE;
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r       <= '0;
      idx_r       <= '0;
      payload_r   <= '0;
      total_r     <= '0;
      wren_r      <= 1'b0;
      data_r      <= 1'b0;
      wraddress_r <= '0;
      done_r      <= 1'b0;
      result_r    <= 32'h0000_0000;
    end else begin
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      payload_r   <= payload_nxt_s;
      total_r     <= total_nxt_s;
      wren_r      <= wren_nxt_s;
      data_r      <= data_nxt_s;
      wraddress_r <= wraddress_nxt_s;
      done_r      <= done_nxt_s;
      result_r    <= result_nxt_s;
    end
  end

  assign wren       = wren_r;
  assign data       = data_r;
  assign wraddress  = wraddress_r;
  assign cmd.done   = done_r;
  assign cmd.result = result_r;

endmodule

// File: tb/tb_escritor_quadro.sv
// Self-checking bench for escritor_quadro: a reference model turns every
// accepted command into expected RAM writes and a done event (with the cycle
// each must appear in); a monitor pops and compares whenever the DUT shows
// wren or done.
module tb_escritor_quadro;

  logic        clk;
  logic        reset;
  logic        wren;
  logic        data;
  logic [11:0] wraddress;

  escritor_quadro_if bus();

  escritor_quadro dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (bus),
    .wren      (wren),
    .data      (data),
    .wraddress (wraddress)
  );

  typedef struct {
    int addr;
    int bit_v;
    int cyc;
  } wr_t;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } dn_t;

  wr_t wq[$];
  dn_t dq[$];

  int cyc     = 0;
  int next_ok = 0;
  int checks  = 0;
  int errors  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: command accepted at sampling edge t.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input int t);
    int op;
    int base;
    int n;
    wr_t w;
    dn_t d;
    op   = int'(a[31:28]);
    base = int'(a[11:0]);
    n    = (op == 0) ? 1 : (op == 1) ? 32 : (op == 2) ? 4096 : 0;
    for (int i = 0; i < n; i++) begin
      w.addr  = (op == 2) ? i : (base + i) % 4096;
      w.bit_v = (op == 1) ? int'(b[i]) : int'(b[0]);
      w.cyc   = t + i;
      wq.push_back(w);
    end
    d.res = (n > 0) ? 32'(n) : (op == 3) ? 32'h5646_0040 : 32'hFFFF_FFFF;
    d.cyc = t + n;
    dq.push_back(d);
    next_ok = t + n + 2;
  endtask

  // Drive one start pulse; the model decides whether the DUT should accept it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int t;
    @(negedge clk);
    bus.dataa = a;
    bus.datab = b;
    bus.start = 1'b1;
    t = cyc + 1;
    if (t >= next_ok) model(a, b, t);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_ready();
    while (cyc + 1 < next_ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    wq.delete();
    dq.delete();
    next_ok = 0;
    #1;
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_wraddress", 32'(wraddress), 32'd0);
    check("rst_result", bus.result, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Monitor: every wren / done cycle must match the next expected event.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (wren === 1'b1) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wren: got addr %0d data %0d expected no write (cycle %0d)",
                   wraddress, data, cyc);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", 32'(wraddress), 32'(e.addr));
          check("wr_data", 32'(data), 32'(e.bit_v));
          check("wr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.done === 1'b1) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got result %h expected no done (cycle %0d)",
                   bus.result, cyc);
        end else begin
          dn_t e;
          e = dq.pop_front();
          check("done_result", bus.result, e.res);
          check("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  logic [3:0] op_v;
  int         sel;

  initial begin
    reset     = 1'b0;
    bus.dataa = 32'h0;
    bus.datab = 32'h0;
    bus.start = 1'b0;
    #12;
    do_reset();
    repeat (2) @(posedge clk);

    // Directed: pixel, word across the wrap point, ID, illegal opcode.
    issue(32'h0000_0041, 32'h0000_0001);
    wait_ready();
    issue(32'h1000_0FF0, 32'h8000_0001);
    wait_ready();
    issue(32'h3000_0000, 32'h0);
    wait_ready();
    issue(32'h7000_0000, 32'h0);
    wait_ready();

    // Fill with a stray start ten cycles in.
    issue(32'h2000_0000, 32'h0000_0001);
    repeat (8) @(negedge clk);
    issue(32'h0000_0005, 32'h0000_0000);
    wait_ready();

    // Back-to-back: start on the done cycle is ignored, the next cycle is accepted.
    issue(32'h0000_0123, 32'h0000_0001);
    while (cyc + 2 < next_ok) begin
      @(posedge clk);
      #1;
    end
    issue(32'h3000_0000, 32'h0);
    issue(32'h0000_0124, 32'h0000_0000);
    wait_ready();

    // Random commands, some deliberately issued while busy.
    for (int k = 0; k < 30; k++) begin
      sel  = $urandom_range(0, 9);
      op_v = (sel < 4) ? 4'd0 : (sel < 7) ? 4'd1 : (sel == 7) ? 4'd3
                                                : 4'($urandom_range(4, 15));
      if ($urandom_range(0, 2) != 0) begin
        wait_ready();
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      issue({op_v, 28'($urandom)}, $urandom);
    end
    wait_ready();

    // Reset in the middle of a fill: writes and done must stop for good.
    issue(32'h2000_0000, 32'h0000_0001);
    repeat (98) @(posedge clk);
    #1;
    check("fill_active", 32'(wren), 32'd1);
    do_reset();
    repeat (10) @(posedge clk);
    issue(32'h0000_0041, 32'h0000_0000);
    wait_ready();

    repeat (5) @(posedge clk);
    #1;
    check("pending_writes", 32'(wq.size()), 32'd0);
    check("pending_done", 32'(dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
